udma_spim_mch_reg_if: RTL
=========================

# udma_spim_mch_reg_if

Parametrised register interface for the uDMA SPI master, generalised from the fixed CMD/RX/TX triple to `NCH` uniform channels. Each channel has its own start-address, size and config registers, and can be programmed from the APB-side cfg bus or from the in-stream setup commands (`SPI_CMD_SETUP_UCA` / `SPI_CMD_SETUP_UCS`). New behaviour per channel:
- a one-entry hold slot that defers an enable while the uDMA channel has both slots busy;
- a sticky overflow flag;
- a bus-stall handshake instead of silently dropping colliding writes.

## Interface
Parameters:
- `L2_AWIDTH_NOAL`, 12, L2 address width per channel.
- `TRANS_SIZE`, 16, transfer size width per channel; must be ≤ 23.
- `NCH`, 3, channel count, 1..8.

Ports (slice for channel c is `[c*W +: W]`):
- `clk_i`  in  1  clock.
- `rstn_i`  in  1  reset. One clock; reset is asynchronous and active-low.
- `cfg_data_i`  in  32  write data.
- `cfg_addr_i`  in  5  word address: channel = addr[4:2], reg = addr[1:0].
- `cfg_valid_i`  in  1  bus request.
- `cfg_rwn_i`  in  1  1 = read, 0 = write.
- `cfg_data_o`  out  32  read data, combinational.
- `cfg_ready_o`  out  1  bus accept.
- `cfg_startaddr_o`  out  NCH*L2_AWIDTH_NOAL  per-channel start address.
- `cfg_size_o`  out  NCH*TRANS_SIZE  per-channel size.
- `cfg_datasize_o`  out  NCH*2  per-channel datasize.
- `cfg_continuous_o`  out  NCH  per-channel continuous mode.
- `cfg_en_o`  out  NCH  one-cycle enable pulse.
- `cfg_clr_o`  out  NCH  one-cycle clear pulse.
- `cfg_en_i`  in  NCH  channel running.
- `cfg_pending_i`  in  NCH  channel's second slot occupied.
- `cfg_curr_addr_i`  in  NCH*L2_AWIDTH_NOAL  current address.
- `cfg_bytes_left_i`  in  NCH*TRANS_SIZE  bytes remaining.
- `udma_cmd_i`  in  32  command word.
- `udma_cmd_valid_i`  in  1  command word valid.
- `udma_cmd_ready_i`  in  1  command word consumed.

## Operation

Register map, per channel at base 4c:
- +0 SADDR
  - W: live start address.
  - R: `cfg_curr_addr_i`.
- +1 SIZE
  - W: live size.
  - R: `cfg_bytes_left_i`, zero-extended.
- +2 CFG
  - W: bit5 clr, bit4 en, bits[2:1] datasize, bit0 continuous.
  - R: `{26'h0, pending_i, en_i, 1'b0, datasize, continuous}`.
- +3 STATUS
  - R: `{30'h0, held, ovf}`.
  - W: bit0 = 1 clears ovf.
- Unmapped address, or channel ≥ NCH: write ignored, read returns 0.

Command decode:
- Fires when `udma_cmd_valid_i & udma_cmd_ready_i` and opcode [31:28] is UCA or UCS.
- Channel index is [27:25]. An index ≥ NCH is ignored.
- UCA: SADDR ← [L2_AWIDTH_NOAL-1:0].
- UCS: SIZE ← [TRANS_SIZE-1:0], datasize ← [24:23], and raises an enable request.

Enable request (CFG write with bit4 = 1, or UCS). "Blocked" means `cfg_en_i[c] & cfg_pending_i[c]`.
- Per-channel FSM states: IDLE, HELD, FIRE.
- IDLE, not blocked: `cfg_en_o[c]` pulses on the next cycle. Outputs show the live registers.
- IDLE, blocked: go to HELD. Snapshot the post-edge SADDR and SIZE values.
- HELD: when `cfg_pending_i[c]` = 0, go to FIRE.
- FIRE: `cfg_en_o[c]` = 1 for one cycle, then go to IDLE.
- In HELD and FIRE, `cfg_startaddr_o` and `cfg_size_o` for c show the snapshot. Live registers remain writable.
- Enable request while HELD or FIRE: dropped; ovf ← 1.
- Clear (bit5):
  - `cfg_clr_o[c]` pulses on the next cycle.
  - FSM → IDLE; the held entry is discarded.
  - Clear has priority over an en bit in the same write (the en bit is ignored).

Collision:
- A command decode and a cfg write in the same cycle: the command wins.
- `cfg_ready_o` = 0 for that cycle. The write is not performed and the master retries.
- Reads are never stalled. Otherwise `cfg_ready_o` = 1.

## Timing
- Reset values:
  - All startaddr, size, continuous = 0; datasize = 2'b10.
  - `cfg_en_o`, `cfg_clr_o` = 0.
  - All FSMs IDLE; held = 0, ovf = 0.
  - `cfg_ready_o` = 1.
- Writes take effect at the accepting edge. Outputs update the cycle after acceptance.
- Enable and clear pulses are registered and exactly one cycle wide.
- HELD exit latency: `cfg_pending_i` low in cycle t → FIRE (en pulse) in cycle t+1.
- Reset asserted mid-HELD or mid-FIRE: immediate IDLE, no pulse.

## Test plan
1. Reset → all outputs at reset values, `cfg_ready_o` = 1, every STATUS reads 0, CFG reads datasize 2'b10.
2. Write ch1 SADDR = 0x123, SIZE = 0x40, CFG = 0x10 with ch1 idle → next cycle `cfg_en_o` = 3'b010, ch1 slices = 0x123 / 0x40; pulse lasts exactly one cycle.
3. With ch2 `cfg_en_i` = `cfg_pending_i` = 1: write SIZE = 0x20, CFG = 0x10, then SIZE = 0x99 → STATUS = 2'b10, `cfg_size_o` ch2 = 0x20. Drop pending → one-cycle `cfg_en_o[2]` with size 0x20, then the slice shows 0x99.
4. Second enable while ch2 HELD → ovf = 1, no extra pulse. Write STATUS = 1 → ovf = 0.
5. UCS word for ch0, size 0x10, ds = 2'b01, accepted in the same cycle as a cfg write to ch0 SADDR → `cfg_ready_o` = 0 that cycle, size = 0x10, datasize = 01, en pulse. The retried write lands next cycle.
6. CFG = 0x30 on a HELD channel → `cfg_clr_o` pulse, no `cfg_en_o`, STATUS held = 0. UCS with index 7 when NCH = 3 → no state change.

Source files
------------

// File: rtl/udma_spim_mch_reg_if.sv
// Multi-channel register interface for the uDMA SPI master: per-channel
// address/size/config registers, in-stream setup decode and deferred enables.
module udma_spim_mch_reg_if #(
  parameter int L2_AWIDTH_NOAL = 12,
  parameter int TRANS_SIZE     = 16,
  parameter int NCH            = 3
) (
  input  logic                           clk_i,
  input  logic                           rstn_i,
  input  logic [31:0]                    cfg_data_i,
  input  logic [4:0]                     cfg_addr_i,
  input  logic                           cfg_valid_i,
  input  logic                           cfg_rwn_i,
  output logic [31:0]                    cfg_data_o,
  output logic                           cfg_ready_o,
  output logic [NCH*L2_AWIDTH_NOAL-1:0]  cfg_startaddr_o,
  output logic [NCH*TRANS_SIZE-1:0]      cfg_size_o,
  output logic [NCH*2-1:0]               cfg_datasize_o,
  output logic [NCH-1:0]                 cfg_continuous_o,
  output logic [NCH-1:0]                 cfg_en_o,
  output logic [NCH-1:0]                 cfg_clr_o,
  input  logic [NCH-1:0]                 cfg_en_i,
  input  logic [NCH-1:0]                 cfg_pending_i,
  input  logic [NCH*L2_AWIDTH_NOAL-1:0]  cfg_curr_addr_i,
  input  logic [NCH*TRANS_SIZE-1:0]      cfg_bytes_left_i,
  input  logic [31:0]                    udma_cmd_i,
  input  logic                           udma_cmd_valid_i,
  input  logic                           udma_cmd_ready_i
);

  localparam int          AW      = L2_AWIDTH_NOAL;
  localparam int          TS      = TRANS_SIZE;
  localparam logic [3:0]  CMD_UCA = 4'hD;
  localparam logic [3:0]  CMD_UCS = 4'hE;
  localparam logic [3:0]  NCH_W   = 4'(NCH);

  typedef enum logic [1:0] {ST_IDLE, ST_HELD, ST_FIRE} state_e;

  logic [3:0]  cmd_op;
  logic [2:0]  cmd_ch;
  logic        cmd_fire;
  logic        cmd_ch_ok;
  logic        wr_en;
  logic [31:0] rdata_ch [NCH];

  assign cmd_op    = udma_cmd_i[31:28];
  assign cmd_ch    = udma_cmd_i[27:25];
  assign cmd_fire  = udma_cmd_valid_i & udma_cmd_ready_i & ((cmd_op == CMD_UCA) | (cmd_op == CMD_UCS));
  assign cmd_ch_ok = ({1'b0, cmd_ch} < NCH_W);

  // A colliding bus write is stalled rather than dropped; the master retries.
  assign wr_en       = cfg_valid_i & ~cfg_rwn_i & ~cmd_fire;
  assign cfg_ready_o = ~(cfg_valid_i & ~cfg_rwn_i & cmd_fire);

  always_comb begin
    cfg_data_o = 32'h0;
    for (int c = 0; c < NCH; c++) begin
      if (cfg_addr_i[4:2] == 3'(c)) cfg_data_o = rdata_ch[c];
    end
  end

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    logic [AW-1:0] saddr_q, saddr_d, snap_saddr_q, snap_saddr_d;
    logic [TS-1:0] size_q, size_d, snap_size_q, snap_size_d;
    logic [1:0]    ds_q, ds_d;
    logic          cont_q, cont_d, ovf_q, ovf_d, en_q, en_d, clr_q, clr_d;
    state_e        state_q, state_d;
    logic          wr_sel, cmd_sel, req, clr, blocked;

    assign wr_sel  = wr_en & (cfg_addr_i[4:2] == 3'(c));
    assign cmd_sel = cmd_fire & cmd_ch_ok & (cmd_ch == 3'(c));
    assign clr     = wr_sel & (cfg_addr_i[1:0] == 2'd2) & cfg_data_i[5];
    assign req     = (wr_sel & (cfg_addr_i[1:0] == 2'd2) & cfg_data_i[4] & ~cfg_data_i[5])
                   | (cmd_sel & (cmd_op == CMD_UCS));
    assign blocked = cfg_en_i[c] & cfg_pending_i[c];

    always_comb begin
      saddr_d = saddr_q;
      size_d  = size_q;
      ds_d    = ds_q;
      cont_d  = cont_q;
      if (wr_sel) begin
        case (cfg_addr_i[1:0])
          2'd0:    saddr_d = cfg_data_i[AW-1:0];
          2'd1:    size_d  = cfg_data_i[TS-1:0];
          2'd2:    begin cont_d = cfg_data_i[0]; ds_d = cfg_data_i[2:1]; end
          default: ;
        endcase
      end
      if (cmd_sel & (cmd_op == CMD_UCA)) saddr_d = udma_cmd_i[AW-1:0];
      if (cmd_sel & (cmd_op == CMD_UCS)) begin
        size_d = udma_cmd_i[TS-1:0];
        ds_d   = udma_cmd_i[24:23];
      end
    end

    // Snapshot takes the post-edge values so a same-cycle setup command is captured.
    always_comb begin
      state_d      = state_q;
      en_d         = 1'b0;
      clr_d        = clr;
      ovf_d        = ovf_q;
      snap_saddr_d = snap_saddr_q;
      snap_size_d  = snap_size_q;
      if (wr_sel & (cfg_addr_i[1:0] == 2'd3) & cfg_data_i[0]) ovf_d = 1'b0;
      if (clr) begin
        state_d = ST_IDLE;
      end else begin
        case (state_q)
          ST_IDLE: if (req) begin
            if (blocked) begin
              state_d      = ST_HELD;
              snap_saddr_d = saddr_d;
              snap_size_d  = size_d;
            end else begin
              en_d = 1'b1;
            end
          end
          ST_HELD: begin
            if (req) ovf_d = 1'b1;
            if (~cfg_pending_i[c]) begin
              state_d = ST_FIRE;
              en_d    = 1'b1;
            end
          end
          ST_FIRE: begin
            if (req) ovf_d = 1'b1;
            state_d = ST_IDLE;
          end
          default: state_d = ST_IDLE;
        endcase
      end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
        saddr_q      <= '0;
        size_q       <= '0;
        ds_q         <= 2'b10;
        cont_q       <= 1'b0;
        snap_saddr_q <= '0;
        snap_size_q  <= '0;
        ovf_q        <= 1'b0;
        en_q         <= 1'b0;
        clr_q        <= 1'b0;
        state_q      <= ST_IDLE;
      end else begin
        saddr_q      <= saddr_d;
        size_q       <= size_d;
        ds_q         <= ds_d;
        cont_q       <= cont_d;
        snap_saddr_q <= snap_saddr_d;
        snap_size_q  <= snap_size_d;
        ovf_q        <= ovf_d;
        en_q         <= en_d;
        clr_q        <= clr_d;
        state_q      <= state_d;
      end
    end

    assign cfg_startaddr_o[c*AW +: AW] = (state_q == ST_IDLE) ? saddr_q : snap_saddr_q;
    assign cfg_size_o[c*TS +: TS]      = (state_q == ST_IDLE) ? size_q  : snap_size_q;
    assign cfg_datasize_o[c*2 +: 2]    = ds_q;
    assign cfg_continuous_o[c]         = cont_q;
    assign cfg_en_o[c]                 = en_q;
    assign cfg_clr_o[c]                = clr_q;

    assign rdata_ch[c] =
      (cfg_addr_i[1:0] == 2'd0) ? {{(32-AW){1'b0}}, cfg_curr_addr_i[c*AW +: AW]} :
      (cfg_addr_i[1:0] == 2'd1) ? {{(32-TS){1'b0}}, cfg_bytes_left_i[c*TS +: TS]} :
      (cfg_addr_i[1:0] == 2'd2) ? {26'h0, cfg_pending_i[c], cfg_en_i[c], 1'b0, ds_q, cont_q} :
                                  {30'h0, (state_q == ST_HELD), ovf_q};
  end

endmodule
